// File: rtl/half_adder_core.sv
// half_adder_core: bank of independent 1-bit half adders with a registered
// copy of the results and a saturating carry-event counter for debug.
module half_adder_core #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  // Width needed to hold a popcount of WIDTH lanes.
  localparam int unsigned PopW = $clog2(WIDTH + 1);
  localparam int unsigned ExtW = CNT_W + PopW;

  logic [PopW-1:0]  carry_pop;
  logic [ExtW-1:0]  count_ext;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Lanes are independent; no carry ripples between them.
  assign sum   = a ^ b;
  assign carry = a & b;

  // Count how many lanes produce a carry this cycle.
  always_comb begin
    carry_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry_pop = carry_pop + PopW'(carry[i]);
    end
  end

  // Widened add, then clamp at all-ones so the counter never wraps.
  always_comb begin
    count_ext = {{PopW{1'b0}}, count_q} + {{CNT_W{1'b0}}, carry_pop};
    if (count_ext[ExtW-1:CNT_W] != '0) begin
      count_d = '1;
    end else begin
      count_d = count_ext[CNT_W-1:0];
    end
  end

  // Registered results and counter; reset wins over a simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
      count_q   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        carry_q <= carry;
        count_q <= count_d;
      end
    end
  end

  assign carry_count = count_q;

endmodule

// File: tb/tb_half_adder_core.sv
// Bench for half_adder_core: WIDTH=1 truth table, WIDTH=8 directed and random
// traffic, and a CNT_W=4 instance sharing the WIDTH=8 stimulus for saturation.
module tb_half_adder_core;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b1;

  // WIDTH=1 instance
  logic a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic sum1, carry1, sum_q1, carry_q1, ov1;
  logic [15:0] cnt1;

  // WIDTH=8 instances (shared stimulus)
  logic [7:0] a8 = '0, b8 = '0;
  logic v8 = 1'b0;
  logic [7:0] sum8, carry8, sum_q8, carry_q8;
  logic ov8;
  logic [15:0] cnt8;
  logic [7:0] sum_s, carry_s, sum_q_s, carry_q_s;
  logic ov_s;
  logic [3:0] cnt_s;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [7:0] m_sum_q = '0, m_carry_q = '0;
  logic m_ov = 1'b0;
  int m_cnt16 = 0, m_cnt4 = 0;

  always #5 clk = clk_en ? ~clk : 1'b0;

  half_adder_core #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
    .out_valid(ov1), .carry_count(cnt1)
  );

  half_adder_core #(.WIDTH(8), .CNT_W(16)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
    .out_valid(ov8), .carry_count(cnt8)
  );

  half_adder_core #(.WIDTH(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .sum(sum_s), .carry(carry_s), .sum_q(sum_q_s), .carry_q(carry_q_s),
    .out_valid(ov_s), .carry_count(cnt_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-lane arithmetic: the two-bit sum of the operands, low bit and high bit.
  function automatic logic [7:0] ref_sum(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
    return r;
  endfunction

  function automatic logic [7:0] ref_carry(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ((int'(x[i]) + int'(y[i])) / 2) == 1;
    return r;
  endfunction

  function automatic int ref_ones(input logic [7:0] x);
    int n = 0;
    for (int i = 0; i < 8; i++) if (x[i]) n++;
    return n;
  endfunction

  // One clock cycle on the WIDTH=8 pair: drive, check comb, clock, check regs.
  task automatic cyc(input logic [7:0] ta, input logic [7:0] tb, input logic tv, input logic tr);
    a8 = ta; b8 = tb; v8 = tv; rst = tr;
    #1;
    check_eq("sum8", 32'(sum8), 32'(ref_sum(ta, tb)));
    check_eq("carry8", 32'(carry8), 32'(ref_carry(ta, tb)));
    check_eq("carry_s", 32'(carry_s), 32'(ref_carry(ta, tb)));
    @(posedge clk);
    if (tr) begin
      m_sum_q = '0; m_carry_q = '0; m_ov = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      m_ov = tv;
      if (tv) begin
        m_sum_q   = ref_sum(ta, tb);
        m_carry_q = ref_carry(ta, tb);
        m_cnt16   = m_cnt16 + ref_ones(m_carry_q);
        m_cnt4    = m_cnt4 + ref_ones(m_carry_q);
        if (m_cnt16 > 65535) m_cnt16 = 65535;
        if (m_cnt4 > 15) m_cnt4 = 15;
      end
    end
    #1;
    check_eq("sum_q8", 32'(sum_q8), 32'(m_sum_q));
    check_eq("carry_q8", 32'(carry_q8), 32'(m_carry_q));
    check_eq("out_valid8", 32'(ov8), 32'(m_ov));
    check_eq("count16", 32'(cnt8), m_cnt16);
    check_eq("sum_q_s", 32'(sum_q_s), 32'(m_sum_q));
    check_eq("out_valid_s", 32'(ov_s), 32'(m_ov));
    check_eq("count4", 32'(cnt_s), m_cnt4);
  endtask

  initial begin
    // Combinational truth table with the clock stopped and reset held.
    for (int i = 0; i < 4; i++) begin
      a1 = i[0]; b1 = i[1];
      #100;
      check_eq("tt_sum", 32'(sum1), ((i % 2) + (i / 2)) % 2);
      check_eq("tt_carry", 32'(carry1), ((i % 2) + (i / 2)) / 2);
    end

    clk_en = 1'b1;
    @(posedge clk); #1;
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("rst_sum_q", 32'(sum_q8), 0);
    check_eq("rst_count", 32'(cnt8), 0);
    check_eq("rst_w1_valid", 32'(ov1), 0);

    // Directed registered path.
    cyc(8'hF0, 8'hCC, 1'b1, 1'b0);
    check_eq("dir_sum_q", 32'(sum_q8), 32'h3C);
    check_eq("dir_carry_q", 32'(carry_q8), 32'hC0);
    check_eq("dir_valid", 32'(ov8), 1);
    check_eq("dir_count", 32'(cnt8), 2);

    // Hold: in_valid low while operands change.
    for (int i = 0; i < 3; i++) cyc(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    check_eq("hold_sum_q", 32'(sum_q8), 32'h3C);
    check_eq("hold_carry_q", 32'(carry_q8), 32'hC0);
    check_eq("hold_count", 32'(cnt8), 2);
    check_eq("hold_valid", 32'(ov8), 0);

    // Reset priority over valid input.
    cyc(8'hFF, 8'hFF, 1'b1, 1'b1);
    check_eq("rp_carry_q", 32'(carry_q8), 0);
    check_eq("rp_count", 32'(cnt8), 0);
    check_eq("rp_valid", 32'(ov8), 0);

    // Saturation on the CNT_W=4 instance.
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    check_eq("sat_first", 32'(cnt_s), 8);
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    check_eq("sat_second", 32'(cnt_s), 15);
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    check_eq("sat_hold", 32'(cnt_s), 15);
    check_eq("nosat_count16", 32'(cnt8), 24);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 1000; i++) begin
      cyc(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
